// File: rtl/world_map_pkg.sv
// Shared definitions for the world tile map: FSM states, tile codes and
// default geometry used by the map, VGA and collision blocks.
package world_map_pkg;

    localparam int unsigned WORLD_ADDR_W = 14;
    localparam int unsigned WORLD_DATA_W = 2;

    localparam logic [WORLD_DATA_W-1:0] TILE_EMPTY = 2'd0;
    localparam logic [WORLD_DATA_W-1:0] TILE_WALL  = 2'd1;
    localparam logic [WORLD_DATA_W-1:0] TILE_ITEM  = 2'd2;
    localparam logic [WORLD_DATA_W-1:0] TILE_ROBOT = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/world_map_bank.sv
// Simple dual-port 1W1R synchronous RAM with an enabled, registered read port.
// Read data holds while re is low; no reset so it maps onto block RAM.
module world_map_bank #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/world_map_ram.sv
// Tile-map memory: one write port, NUM_RD synchronous read ports with
// write-first bypass, and a hardware engine that fills the map with FILL_VALUE.
module world_map_ram
    import world_map_pkg::*;
#(
    parameter int unsigned       ADDR_W     = WORLD_ADDR_W,
    parameter int unsigned       DATA_W     = WORLD_DATA_W,
    parameter int unsigned       NUM_RD     = 2,
    parameter logic [DATA_W-1:0] FILL_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_req,
    output logic                     clear_busy,
    output logic                     clear_done,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid
);

    fsm_state_t        state;
    logic [ADDR_W-1:0] fill_cnt;

    logic              wr_fire;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] bank_q [NUM_RD];
    logic [DATA_W-1:0] ovr_q  [NUM_RD];
    logic [NUM_RD-1:0] use_ram;

    assign wr_fire = wr_en & wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fill_cnt   <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
            wr_ready   <= 1'b1;
        end else begin
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state      <= CLEAR;
                        fill_cnt   <= '0;
                        clear_busy <= 1'b1;
                        wr_ready   <= 1'b0;
                    end
                end
                CLEAR: begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt == '1) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                        wr_ready   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = fill_cnt;
            mem_wdata = FILL_VALUE;
        end else if (wr_fire) begin
            mem_we = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_bank
        world_map_bank #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_bank (
            .clk   (clk),
            .we    (mem_we),
            .waddr (mem_waddr),
            .wdata (mem_wdata),
            .re    (rd_en[g]),
            .raddr (rd_addr[g*ADDR_W +: ADDR_W]),
            .rdata (bank_q[g])
        );
    end

    // The banks read-before-write, so fill and same-address writes are
    // captured here and override the bank output on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= '0;
            use_ram  <= '0;
            for (int unsigned i = 0; i < NUM_RD; i++) begin
                ovr_q[i] <= '0;
            end
        end else begin
            rd_valid <= rd_en;
            for (int unsigned i = 0; i < NUM_RD; i++) begin
                if (rd_en[i]) begin
                    if (state == CLEAR) begin
                        use_ram[i] <= 1'b0;
                        ovr_q[i]   <= FILL_VALUE;
                    end else if (wr_fire && (wr_addr == rd_addr[i*ADDR_W +: ADDR_W])) begin
                        use_ram[i] <= 1'b0;
                        ovr_q[i]   <= wr_data;
                    end else begin
                        use_ram[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd_data[i*DATA_W +: DATA_W] = use_ram[i] ? bank_q[i] : ovr_q[i];
        end
    end

endmodule

// File: tb/tb_world_map_ram.sv
// Randomised and directed bench for world_map_ram (16-entry, 2 ports, fill 01)
// against an array-based reference model of the tile map.
module tb_world_map_ram;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 2;
    localparam int unsigned NR    = 2;
    localparam int          DEPTH = 16;
    localparam logic [1:0]  FILL  = 2'b01;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear_req = 1'b0;
    logic          clear_busy;
    logic          clear_done;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic [NR-1:0] rd_en = '0;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0] rd_valid;

    world_map_ram #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .NUM_RD     (NR),
        .FILL_VALUE (FILL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: tile contents, which tiles hold a defined value,
    // and how many fill writes of a running clear are still outstanding.
    logic [1:0] mem   [DEPTH];
    bit         known [DEPTH];
    int         m_left;
    logic [1:0] exp_d [NR];
    bit         exp_k [NR];
    logic [1:0] exp_v;
    bit         exp_done;

    task automatic model_reset();
        m_left   = 0;
        exp_v    = '0;
        exp_done = 0;
        for (int p = 0; p < NR; p++) begin
            exp_d[p] = '0;
            exp_k[p] = 1;
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] wa, input logic [1:0] wd,
                         input logic cr, input logic [1:0] re,
                         input logic [3:0] a0, input logic [3:0] a1);
        logic [3:0] ra [NR];
        bit busy_now;
        bit accept;
        ra[0] = a0;
        ra[1] = a1;
        wr_en = we; wr_addr = wa; wr_data = wd; clear_req = cr;
        rd_en = re; rd_addr = {a1, a0};
        busy_now = (m_left != 0);
        accept   = we && !busy_now;
        for (int p = 0; p < NR; p++) begin
            if (re[p]) begin
                if (busy_now) begin
                    exp_d[p] = FILL; exp_k[p] = 1;
                end else if (accept && wa == ra[p]) begin
                    exp_d[p] = wd; exp_k[p] = 1;
                end else begin
                    exp_d[p] = mem[ra[p]]; exp_k[p] = known[ra[p]];
                end
            end
        end
        exp_v    = re;
        exp_done = 0;
        if (busy_now) begin
            mem[DEPTH - m_left]   = FILL;
            known[DEPTH - m_left] = 1;
            m_left--;
            if (m_left == 0) exp_done = 1;
        end else begin
            if (accept) begin
                mem[wa] = wd; known[wa] = 1;
            end
            if (cr) m_left = DEPTH;
        end
        @(posedge clk);
        #1;
        wr_en = 0; clear_req = 0; rd_en = '0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        for (int a = 0; a < DEPTH; a++) known[a] = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        if (rd_data !== 4'b0000) begin
            $display("FAIL reset_rd_data: got %b want 0000", rd_data); n_err++;
        end
        n_vec++;
        if (rd_valid !== 2'b00) begin
            $display("FAIL reset_rd_valid: got %b want 00", rd_valid); n_err++;
        end
        n_vec++;
        if (clear_busy !== 1'b0 || clear_done !== 1'b0) begin
            $display("FAIL reset_clear: busy %b done %b want 0 0", clear_busy, clear_done); n_err++;
        end
        n_vec++;
        if (wr_ready !== 1'b1) begin
            $display("FAIL reset_wr_ready: got %b want 1", wr_ready); n_err++;
        end
        n_vec++;
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_then_clear();
        int busy_cycles = 0;
        int done_cnt = 0;
        drive(0, 0, 0, 1, 2'b00, 0, 0);
        if (clear_busy) busy_cycles++;
        for (int i = 0; i < 24; i++) begin
            drive(0, 0, 0, 0, 2'b00, 0, 0);
            if (clear_busy) busy_cycles++;
            if (clear_done) done_cnt++;
        end
        if (busy_cycles != DEPTH) begin
            $display("FAIL clear_busy_len: got %0d want %0d", busy_cycles, DEPTH); n_err++;
        end
        n_vec++;
        if (done_cnt != 1) begin
            $display("FAIL clear_done_cnt: got %0d want 1", done_cnt); n_err++;
        end
        n_vec++;
        for (int a = 0; a < DEPTH; a++) begin
            drive(0, 0, 0, 0, 2'b11, 4'(a), 4'(DEPTH - 1 - a));
            if (rd_valid !== 2'b11) begin
                $display("FAIL clear_rd_valid[%0d]: got %b want 11", a, rd_valid); n_err++;
            end
            n_vec++;
            if (rd_data !== {FILL, FILL}) begin
                $display("FAIL clear_rd_data[%0d]: got %b want %b", a, rd_data, {FILL, FILL}); n_err++;
            end
            n_vec++;
        end
        drive(0, 0, 0, 0, 2'b00, 0, 0);
        if (rd_valid !== 2'b00 || rd_data !== {FILL, FILL}) begin
            $display("FAIL rd_hold: valid %b data %b want 00 %b", rd_valid, rd_data, {FILL, FILL}); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_write_read();
        drive(1, 5, 2'b11, 0, 2'b00, 0, 0);
        drive(0, 0, 0, 0, 2'b11, 5, 6);
        if (rd_data !== {2'b01, 2'b11} || rd_data !== {exp_d[1], exp_d[0]}) begin
            $display("FAIL write_read: got %b want %b", rd_data, {exp_d[1], exp_d[0]}); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_bypass();
        drive(1, 9, 2'b10, 0, 2'b11, 9, 9);
        if (rd_data !== 4'b1010 || rd_valid !== 2'b11) begin
            $display("FAIL bypass: data %b valid %b want 1010 11", rd_data, rd_valid); n_err++;
        end
        n_vec++;
        drive(0, 0, 0, 0, 2'b11, 9, 9);
        if (rd_data !== 4'b1010) begin
            $display("FAIL bypass_commit: got %b want 1010", rd_data); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_write_during_clear();
        int busy_cycles = 0;
        int done_cnt = 0;
        drive(1, 3, 2'b11, 0, 2'b00, 0, 0);
        drive(0, 0, 0, 1, 2'b00, 0, 0);
        if (clear_busy) busy_cycles++;
        for (int c = 1; c < 24; c++) begin
            if (c == 4) begin
                if (wr_ready !== 1'b0) begin
                    $display("FAIL wr_ready_in_clear: got %b want 0", wr_ready); n_err++;
                end
                n_vec++;
            end
            drive(c == 4, 3, 2'b11, c == 6, 2'b11, 4'(c), 3);
            if (c <= 10) begin
                if (rd_data !== {FILL, FILL} || rd_valid !== 2'b11) begin
                    $display("FAIL read_in_clear[%0d]: data %b valid %b want %b 11", c, rd_data, rd_valid, {FILL, FILL}); n_err++;
                end
                n_vec++;
            end
            if (clear_busy) busy_cycles++;
            if (clear_done) done_cnt++;
        end
        if (busy_cycles != DEPTH || done_cnt != 1) begin
            $display("FAIL clear_no_extend: busy %0d done %0d want %0d 1", busy_cycles, done_cnt, DEPTH); n_err++;
        end
        n_vec++;
        drive(0, 0, 0, 0, 2'b11, 3, 3);
        if (rd_data !== {FILL, FILL}) begin
            $display("FAIL dropped_write: got %b want %b", rd_data, {FILL, FILL}); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_simul_clear_write();
        int done_cnt = 0;
        drive(1, 7, 2'b11, 1, 2'b01, 7, 0);
        if (rd_data[1:0] !== 2'b11) begin
            $display("FAIL simul_bypass: got %b want 11", rd_data[1:0]); n_err++;
        end
        n_vec++;
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0, 2'b00, 0, 0);
            if (clear_done) done_cnt++;
        end
        drive(0, 0, 0, 0, 2'b11, 7, 7);
        if (done_cnt != 1 || rd_data !== {FILL, FILL}) begin
            $display("FAIL simul_clear: done %0d data %b want 1 %b", done_cnt, rd_data, {FILL, FILL}); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_reset_mid_clear();
        int busy_cycles = 0;
        int done_cnt = 0;
        drive(0, 0, 0, 1, 2'b00, 0, 0);
        for (int c = 1; c < 8; c++) drive(0, 0, 0, 0, 2'b11, 4'(c), 4'(c));
        #2;
        rst_n = 0;
        #1;
        if (rd_valid !== 2'b00 || clear_busy !== 1'b0 || rd_data !== 4'b0000) begin
            $display("FAIL reset_mid_clear: valid %b busy %b data %b want 00 0 0000", rd_valid, clear_busy, rd_data); n_err++;
        end
        n_vec++;
        model_reset();
        @(posedge clk);
        #1;
        if (clear_done !== 1'b0) begin
            $display("FAIL reset_mid_done: got %b want 0", clear_done); n_err++;
        end
        n_vec++;
        rst_n = 1;
        @(posedge clk);
        #1;
        drive(0, 0, 0, 1, 2'b00, 0, 0);
        if (clear_busy) busy_cycles++;
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0, 2'b00, 0, 0);
            if (clear_busy) busy_cycles++;
            if (clear_done) done_cnt++;
        end
        if (busy_cycles != DEPTH || done_cnt != 1) begin
            $display("FAIL reclear: busy %0d done %0d want %0d 1", busy_cycles, done_cnt, DEPTH); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_random();
        logic       we, cr;
        logic [3:0] wa, a0, a1;
        logic [1:0] wd, re;
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom_range(0, 1));
            wa = 4'($urandom_range(0, DEPTH - 1));
            wd = 2'($urandom_range(0, 3));
            cr = ($urandom_range(0, 79) == 0);
            re = 2'($urandom_range(0, 3));
            a0 = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, DEPTH - 1));
            a1 = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, DEPTH - 1));
            if (wr_ready !== (m_left == 0)) begin
                $display("FAIL rand_wr_ready[%0d]: got %b want %b", i, wr_ready, m_left == 0); n_err++;
            end
            n_vec++;
            drive(we, wa, wd, cr, re, a0, a1);
            if (rd_valid !== exp_v) begin
                $display("FAIL rand_rd_valid[%0d]: got %b want %b", i, rd_valid, exp_v); n_err++;
            end
            n_vec++;
            for (int p = 0; p < NR; p++) begin
                if (exp_k[p]) begin
                    if (rd_data[p*DW +: DW] !== exp_d[p]) begin
                        $display("FAIL rand_rd_data[%0d] port %0d: got %b want %b", i, p, rd_data[p*DW +: DW], exp_d[p]); n_err++;
                    end
                    n_vec++;
                end
            end
            if (clear_busy !== (m_left != 0) || clear_done !== exp_done) begin
                $display("FAIL rand_clear[%0d]: busy %b done %b want %b %b", i, clear_busy, clear_done, m_left != 0, exp_done); n_err++;
            end
            n_vec++;
        end
    endtask

    initial begin
        test_reset();
        test_reset_then_clear();
        test_write_read();
        test_bypass();
        test_write_during_clear();
        test_simul_clear_write();
        test_reset_mid_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
